// File: rtl/pipeline_stall_controller_pkg.sv
// rtl/pipeline_stall_controller_pkg.sv - run-state and action encodings shared with the debug unit
package pipeline_stall_controller_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_STEP = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      ACT_FREEZE = 2'd0,
      ACT_FLUSH  = 2'd1,
      ACT_BUBBLE = 2'd2,
      ACT_ADV    = 2'd3
   } action_t;

   typedef struct packed {
      logic pc_we;
      logic ifid_we;
      logic ifid_flush;
      logic idex_flush;
      logic exmem_we;
      logic memwb_we;
   } ctrl_t;

   // Flushing IF/ID always writes it too, so ifid_flush never appears without ifid_we.
   function automatic ctrl_t action_ctrl(input action_t act);
      ctrl_t c;
      c = '0;
      case (act)
         ACT_FLUSH:  c = '{pc_we: 1'b1, ifid_we: 1'b1, ifid_flush: 1'b1, idex_flush: 1'b1,
                           exmem_we: 1'b1, memwb_we: 1'b1};
         ACT_BUBBLE: c = '{pc_we: 1'b0, ifid_we: 1'b0, ifid_flush: 1'b0, idex_flush: 1'b1,
                           exmem_we: 1'b1, memwb_we: 1'b1};
         ACT_ADV:    c = '{pc_we: 1'b1, ifid_we: 1'b1, ifid_flush: 1'b0, idex_flush: 1'b0,
                           exmem_we: 1'b1, memwb_we: 1'b1};
         default:    c = '0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/pipe_action_decode.sv
// rtl/pipe_action_decode.sv - per-cycle action select (mem_busy > br_taken > hz_stall > advance)
module pipe_action_decode
   import pipeline_stall_controller_pkg::*;
(
   input  logic    i_active,
   input  logic    i_mem_busy,
   input  logic    i_br_taken,
   input  logic    i_hz_stall,
   output action_t o_act,
   output ctrl_t   o_ctrl
);

   action_t w_act;

   always_comb begin
      w_act = ACT_FREEZE;
      if (i_active && !i_mem_busy) begin
         if (i_br_taken)
            w_act = ACT_FLUSH;
         else if (i_hz_stall)
            w_act = ACT_BUBBLE;
         else
            w_act = ACT_ADV;
      end
   end

   assign o_act  = w_act;
   assign o_ctrl = action_ctrl(w_act);

endmodule

// File: rtl/pipeline_stall_controller.sv
// rtl/pipeline_stall_controller.sv - run-state FSM, stage enables/flushes and cycle/stall counters
module pipeline_stall_controller
   import pipeline_stall_controller_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             hz_stall,
   input  logic             br_taken,
   input  logic             mem_busy,
   input  logic             halt_wb,
   input  logic             dbg_run,
   input  logic             dbg_step,
   input  logic             dbg_halt,
   output logic             pc_we,
   output logic             ifid_we,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             exmem_we,
   output logic             memwb_we,
   output logic             running,
   output logic             done,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] stall_cnt
);

   state_t           r_state;
   state_t           w_next;
   action_t          w_act;
   ctrl_t            w_ctrl;
   logic             w_active;
   logic             w_adv;
   logic [CNT_W-1:0] r_cycle_cnt;
   logic [CNT_W-1:0] r_stall_cnt;

   assign w_active = (r_state == ST_RUN) || (r_state == ST_STEP);

   pipe_action_decode u_decode (
      .i_active   (w_active),
      .i_mem_busy (mem_busy),
      .i_br_taken (br_taken),
      .i_hz_stall (hz_stall),
      .o_act      (w_act),
      .o_ctrl     (w_ctrl)
   );

   assign w_adv = w_ctrl.exmem_we;

   always_ff @(posedge clk) begin
      if (!rst_n)
         r_state <= ST_IDLE;
      else
         r_state <= w_next;
   end

   // dbg_halt in RUN only affects the next state; this cycle's action still happens.
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (dbg_halt)
               w_next = ST_IDLE;
            else if (dbg_step)
               w_next = ST_STEP;
            else if (dbg_run)
               w_next = ST_RUN;
         end
         ST_RUN: begin
            if (halt_wb && w_adv)
               w_next = ST_DONE;
            else if (dbg_halt)
               w_next = ST_IDLE;
         end
         ST_STEP: begin
            if (w_adv)
               w_next = halt_wb ? ST_DONE : ST_IDLE;
         end
         default: w_next = ST_DONE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cycle_cnt <= '0;
         r_stall_cnt <= '0;
      end else begin
         if (w_adv)
            r_cycle_cnt <= r_cycle_cnt + 1'b1;
         if (w_act == ACT_BUBBLE)
            r_stall_cnt <= r_stall_cnt + 1'b1;
      end
   end

   assign pc_we      = w_ctrl.pc_we;
   assign ifid_we    = w_ctrl.ifid_we;
   assign ifid_flush = w_ctrl.ifid_flush;
   assign idex_flush = w_ctrl.idex_flush;
   assign exmem_we   = w_ctrl.exmem_we;
   assign memwb_we   = w_ctrl.memwb_we;
   assign running    = w_active;
   assign done       = (r_state == ST_DONE);
   assign cycle_cnt  = r_cycle_cnt;
   assign stall_cnt  = r_stall_cnt;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// tb/tb_pipeline_stall_controller.sv - directed vector table plus random run against a reference model
module tb_pipeline_stall_controller;

   logic        clk = 1'b0;
   logic        rst_n, hz_stall, br_taken, mem_busy, halt_wb, dbg_run, dbg_step, dbg_halt;
   logic        pc_we, ifid_we, ifid_flush, idex_flush, exmem_we, memwb_we, running, done;
   logic [31:0] cycle_cnt, stall_cnt;

   always #5 clk = ~clk;

   pipeline_stall_controller #(.CNT_W(32)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .hz_stall   (hz_stall),
      .br_taken   (br_taken),
      .mem_busy   (mem_busy),
      .halt_wb    (halt_wb),
      .dbg_run    (dbg_run),
      .dbg_step   (dbg_step),
      .dbg_halt   (dbg_halt),
      .pc_we      (pc_we),
      .ifid_we    (ifid_we),
      .ifid_flush (ifid_flush),
      .idex_flush (idex_flush),
      .exmem_we   (exmem_we),
      .memwb_we   (memwb_we),
      .running    (running),
      .done       (done),
      .cycle_cnt  (cycle_cnt),
      .stall_cnt  (stall_cnt)
   );

   localparam logic [5:0] O_ZERO = 6'b000000;
   localparam logic [5:0] O_ADV  = 6'b110011;
   localparam logic [5:0] O_FL   = 6'b111111;
   localparam logic [5:0] O_BUB  = 6'b000111;

   int total = 0;
   int bad   = 0;

   // Reference model: run mode flags and plain counters.
   bit          m_run, m_step, m_done;
   logic [31:0] m_cyc, m_stall;

   typedef struct {
      logic [7:0] in;   // {rst_n, hz, br, mb, halt_wb, run, step, dhalt}
      logic [5:0] eo;   // {pc_we, ifid_we, ifid_flush, idex_flush, exmem_we, memwb_we}
      logic       er;
      logic       ed;
   } vec_t;

   vec_t tbl[31];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic set_in(input logic [7:0] v);
      {rst_n, hz_stall, br_taken, mem_busy, halt_wb, dbg_run, dbg_step, dbg_halt} = v;
   endtask

   function automatic logic [5:0] model_ctrl();
      if (!(m_run || m_step) || mem_busy) return O_ZERO;
      if (br_taken) return O_FL;
      if (hz_stall) return O_BUB;
      return O_ADV;
   endfunction

   task automatic model_clock();
      logic [5:0] c;
      c = model_ctrl();
      if (!rst_n) begin
         m_run = 0; m_step = 0; m_done = 0; m_cyc = 0; m_stall = 0;
      end else begin
         if (c[1]) m_cyc = m_cyc + 1;
         if (c == O_BUB) m_stall = m_stall + 1;
         if (m_run) begin
            if (halt_wb && c[1]) begin m_run = 0; m_done = 1; end
            else if (dbg_halt) m_run = 0;
         end else if (m_step) begin
            if (c[1]) begin m_step = 0; m_done = halt_wb; end
         end else if (!m_done && !dbg_halt) begin
            if (dbg_step) m_step = 1;
            else if (dbg_run) m_run = 1;
         end
      end
   endtask

   function automatic vec_t mk(input logic [7:0] in, input logic [5:0] eo, input logic er, input logic ed);
      vec_t v;
      v.in = in; v.eo = eo; v.er = er; v.ed = ed;
      return v;
   endfunction

   task automatic do_reset();
      set_in(8'b0000_0000);
      repeat (2) begin
         @(posedge clk);
         model_clock();
      end
      #1;
   endtask

   initial begin
      tbl[0]  = mk(8'b1000_0000, O_ZERO, 0, 0);
      tbl[1]  = mk(8'b1110_0000, O_ZERO, 0, 0);
      tbl[2]  = mk(8'b1000_0100, O_ZERO, 0, 0);
      tbl[3]  = mk(8'b1000_0000, O_ADV,  1, 0);
      tbl[4]  = mk(8'b1100_0000, O_BUB,  1, 0);
      tbl[5]  = mk(8'b1110_0000, O_FL,   1, 0);
      tbl[6]  = mk(8'b1111_0000, O_ZERO, 1, 0);
      tbl[7]  = mk(8'b1111_0000, O_ZERO, 1, 0);
      tbl[8]  = mk(8'b1111_0000, O_ZERO, 1, 0);
      tbl[9]  = mk(8'b1100_0001, O_BUB,  1, 0);
      tbl[10] = mk(8'b1000_0000, O_ZERO, 0, 0);
      tbl[11] = mk(8'b1001_0010, O_ZERO, 0, 0);
      tbl[12] = mk(8'b1001_0000, O_ZERO, 1, 0);
      tbl[13] = mk(8'b1001_0000, O_ZERO, 1, 0);
      tbl[14] = mk(8'b1000_0000, O_ADV,  1, 0);
      tbl[15] = mk(8'b1000_0000, O_ZERO, 0, 0);
      tbl[16] = mk(8'b1000_0100, O_ZERO, 0, 0);
      tbl[17] = mk(8'b1001_1000, O_ZERO, 1, 0);
      tbl[18] = mk(8'b1000_1000, O_ADV,  1, 0);
      tbl[19] = mk(8'b1000_0100, O_ZERO, 0, 1);
      tbl[20] = mk(8'b1000_0010, O_ZERO, 0, 1);
      tbl[21] = mk(8'b0000_0000, O_ZERO, 0, 1);
      tbl[22] = mk(8'b1000_0000, O_ZERO, 0, 0);
      tbl[23] = mk(8'b1000_0111, O_ZERO, 0, 0);
      tbl[24] = mk(8'b1000_0000, O_ZERO, 0, 0);
      tbl[25] = mk(8'b1000_0110, O_ZERO, 0, 0);
      tbl[26] = mk(8'b1000_0000, O_ADV,  1, 0);
      tbl[27] = mk(8'b1000_0000, O_ZERO, 0, 0);
      tbl[28] = mk(8'b1000_0010, O_ZERO, 0, 0);
      tbl[29] = mk(8'b1000_1000, O_ADV,  1, 0);
      tbl[30] = mk(8'b1000_0000, O_ZERO, 0, 1);

      do_reset();

      for (int i = 0; i < 31; i++) begin
         set_in(tbl[i].in);
         #3;
         chk($sformatf("row%0d_ctrl", i),
             {pc_we, ifid_we, ifid_flush, idex_flush, exmem_we, memwb_we, running, done},
             {tbl[i].eo, tbl[i].er, tbl[i].ed});
         chk($sformatf("row%0d_counters", i), {cycle_cnt, stall_cnt}, {m_cyc, m_stall});
         @(posedge clk);
         model_clock();
         #1;
      end

      do_reset();

      for (int n = 0; n < 800; n++) begin
         rst_n    = ($urandom_range(0, 63) != 0);
         hz_stall = $urandom_range(0, 1) == 1;
         br_taken = ($urandom_range(0, 3) == 0);
         mem_busy = ($urandom_range(0, 3) == 0);
         halt_wb  = ($urandom_range(0, 29) == 0);
         dbg_run  = ($urandom_range(0, 7) == 0);
         dbg_step = ($urandom_range(0, 7) == 0);
         dbg_halt = ($urandom_range(0, 11) == 0);
         #3;
         chk($sformatf("rand%0d_ctrl", n),
             {pc_we, ifid_we, ifid_flush, idex_flush, exmem_we, memwb_we, running, done},
             {model_ctrl(), (m_run || m_step), m_done});
         chk($sformatf("rand%0d_counters", n), {cycle_cnt, stall_cnt}, {m_cyc, m_stall});
         @(posedge clk);
         model_clock();
         #1;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
